// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers, used by the frame generator and the transmitter.
package i2s_pkg;

   // 40 MHz / 14 gives roughly 64 x 44.1 kHz bit clock
   localparam int unsigned I2S_CLK_DIVISION    = 8'd14;
   localparam int unsigned I2S_AUDIO_WORD_LEN  = 8'd24;
   localparam int unsigned I2S_AUDIO_FRAME_LEN = 8'd64;

   // Counter width shared by the half-period and bit counters
   localparam int unsigned I2S_CNT_W = 8;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/i2s_sample_buffer.sv
// One-deep sample buffer between the voice source and the I2S word register,
// with underrun detection and a saturating underrun counter.
module i2s_sample_buffer
   import i2s_pkg::*;
#(
   parameter int unsigned AUDIO_WORD_LEN = I2S_AUDIO_WORD_LEN
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      load_event,
   input  logic [AUDIO_WORD_LEN-1:0] s_data_i,
   input  logic                      s_valid_i,
   output logic                      s_ready_o,
   output logic [AUDIO_WORD_LEN-1:0] audio_data_o,
   output logic                      sample_req_o,
   output logic                      underrun_o,
   output logic [15:0]               underrun_cnt_o
);

   logic [AUDIO_WORD_LEN-1:0] pending;
   logic                      full;
   logic                      accept;

   // A load frees the slot in the same cycle, so a push can land on the load cycle
   assign s_ready_o = ~full | load_event;
   assign accept    = s_valid_i & s_ready_o;

   // Pending slot, output word and underrun bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pending        <= '0;
         full           <= 1'b0;
         audio_data_o   <= '0;
         sample_req_o   <= 1'b0;
         underrun_o     <= 1'b0;
         underrun_cnt_o <= '0;
      end else begin
         sample_req_o <= load_event;
         underrun_o   <= load_event & ~full;
         if (load_event && full)
            audio_data_o <= pending;
         if (load_event && !full)
            underrun_cnt_o <= sat_inc16(underrun_cnt_o);
         if (accept) begin
            pending <= s_data_i;
            full    <= 1'b1;
         end else if (load_event) begin
            full <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2s_frame_generator.sv
// I2S bit clock / word select generator feeding a word register from a one-deep buffer.
// The word is loaded at the start of the right half and held for that whole half.
module i2s_frame_generator
   import i2s_pkg::*;
#(
   parameter int unsigned CLK_DIVISION    = I2S_CLK_DIVISION,
   parameter int unsigned AUDIO_WORD_LEN  = I2S_AUDIO_WORD_LEN,
   parameter int unsigned AUDIO_FRAME_LEN = I2S_AUDIO_FRAME_LEN
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic [AUDIO_WORD_LEN-1:0] s_data_i,
   input  logic                      s_valid_i,
   output logic                      s_ready_o,
   output logic [AUDIO_WORD_LEN-1:0] audio_data_o,
   output logic                      audio_bclk_o,
   output logic                      audio_lrclk_o,
   output logic                      sample_req_o,
   output logic                      underrun_o,
   output logic [15:0]               underrun_cnt_o
);

   if ((CLK_DIVISION % 2) != 0 || CLK_DIVISION < 2) begin : g_bad_div
      $error("i2s_frame_generator: CLK_DIVISION must be even and >= 2");
   end
   if ((AUDIO_FRAME_LEN % 2) != 0 || AUDIO_FRAME_LEN < 2 * AUDIO_WORD_LEN) begin : g_bad_frame
      $error("i2s_frame_generator: AUDIO_FRAME_LEN must be even and >= 2*AUDIO_WORD_LEN");
   end

   localparam logic [I2S_CNT_W-1:0] HALF_RELOAD = I2S_CNT_W'(CLK_DIVISION / 2 - 1);
   localparam logic [I2S_CNT_W-1:0] BIT_RELOAD  = I2S_CNT_W'(AUDIO_FRAME_LEN / 2 - 1);

   logic [I2S_CNT_W-1:0] half_cnt;
   logic [I2S_CNT_W-1:0] bit_cnt;
   logic                 half_tick;
   logic                 frame_tick;
   logic                 load_event;

   // A BCLK toggle is due; a frame half ends on the falling toggle with the bit counter spent
   assign half_tick  = enable_i & (half_cnt == '0);
   assign frame_tick = half_tick & audio_bclk_o & (bit_cnt == '0);
   // LRCLK about to go 0->1: start of the right half
   assign load_event = frame_tick & ~audio_lrclk_o;

   // Bit clock, bit counter and word select; everything freezes while disabled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         half_cnt      <= HALF_RELOAD;
         bit_cnt       <= BIT_RELOAD;
         audio_bclk_o  <= 1'b0;
         audio_lrclk_o <= 1'b1;
      end else if (enable_i) begin
         if (half_cnt == '0) begin
            half_cnt     <= HALF_RELOAD;
            audio_bclk_o <= ~audio_bclk_o;
            if (audio_bclk_o) begin
               if (bit_cnt == '0) begin
                  bit_cnt       <= BIT_RELOAD;
                  audio_lrclk_o <= ~audio_lrclk_o;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
         end else begin
            half_cnt <= half_cnt - 1'b1;
         end
      end
   end

   i2s_sample_buffer #(
      .AUDIO_WORD_LEN(AUDIO_WORD_LEN)
   ) u_buf (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .load_event     (load_event),
      .s_data_i       (s_data_i),
      .s_valid_i      (s_valid_i),
      .s_ready_o      (s_ready_o),
      .audio_data_o   (audio_data_o),
      .sample_req_o   (sample_req_o),
      .underrun_o     (underrun_o),
      .underrun_cnt_o (underrun_cnt_o)
   );

endmodule

// File: tb/tb_i2s_frame_generator.sv
// Directed bench for i2s_frame_generator at default parameters.
// cyc counts rising edges since the last reset release; outputs are sampled 1 ns after each edge.
module tb_i2s_frame_generator;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        enable_i;
   logic [23:0] s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [23:0] audio_data_o;
   logic        audio_bclk_o;
   logic        audio_lrclk_o;
   logic        sample_req_o;
   logic        underrun_o;
   logic [15:0] underrun_cnt_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   i2s_frame_generator dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .enable_i       (enable_i),
      .s_data_i       (s_data_i),
      .s_valid_i      (s_valid_i),
      .s_ready_o      (s_ready_o),
      .audio_data_o   (audio_data_o),
      .audio_bclk_o   (audio_bclk_o),
      .audio_lrclk_o  (audio_lrclk_o),
      .sample_req_o   (sample_req_o),
      .underrun_o     (underrun_o),
      .underrun_cnt_o (underrun_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic adv_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic push(input logic [23:0] d);
      s_valid_i = 1'b1;
      s_data_i  = d;
      step();
      s_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; enable_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0;
      repeat (3) step();
      checks++; if (audio_bclk_o !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b expected 0", audio_bclk_o); end
      checks++; if (audio_lrclk_o !== 1'b1) begin errors++; $display("FAIL rst_lrclk: got %b expected 1", audio_lrclk_o); end
      checks++; if (audio_data_o !== 24'h0) begin errors++; $display("FAIL rst_data: got %h expected 000000", audio_data_o); end
      checks++; if (sample_req_o !== 1'b0 || underrun_o !== 1'b0) begin errors++; $display("FAIL rst_pulses: got req=%b und=%b expected 0/0", sample_req_o, underrun_o); end
      checks++; if (underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0000", underrun_cnt_o); end
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", s_ready_o); end
      rst_i = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_clocks_and_load();
      adv_to(6);   checks++; if (audio_bclk_o !== 1'b0) begin errors++; $display("FAIL bclk_c6: got %b expected 0", audio_bclk_o); end
      adv_to(7);   checks++; if (audio_bclk_o !== 1'b1) begin errors++; $display("FAIL bclk_c7: got %b expected 1", audio_bclk_o); end
      adv_to(14);  checks++; if (audio_bclk_o !== 1'b0) begin errors++; $display("FAIL bclk_c14: got %b expected 0", audio_bclk_o); end
      adv_to(21);  checks++; if (audio_bclk_o !== 1'b1) begin errors++; $display("FAIL bclk_c21: got %b expected 1", audio_bclk_o); end
      adv_to(447); checks++; if (audio_lrclk_o !== 1'b1) begin errors++; $display("FAIL lrclk_c447: got %b expected 1", audio_lrclk_o); end
      adv_to(448); checks++; if (audio_lrclk_o !== 1'b0) begin errors++; $display("FAIL lrclk_c448: got %b expected 0", audio_lrclk_o); end
      adv_to(500);
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL ready_empty: got %b expected 1", s_ready_o); end
      push(24'hABCDEF);
      checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL ready_full: got %b expected 0", s_ready_o); end
      adv_to(895);
      checks++; if (audio_lrclk_o !== 1'b0 || sample_req_o !== 1'b0) begin errors++; $display("FAIL pre_load: got lr=%b req=%b expected 0/0", audio_lrclk_o, sample_req_o); end
      checks++; if (audio_data_o !== 24'h0) begin errors++; $display("FAIL pre_load_data: got %h expected 000000", audio_data_o); end
      adv_to(896);
      checks++; if (audio_lrclk_o !== 1'b1) begin errors++; $display("FAIL lrclk_c896: got %b expected 1", audio_lrclk_o); end
      checks++; if (audio_data_o !== 24'hABCDEF) begin errors++; $display("FAIL load_data: got %h expected abcdef", audio_data_o); end
      checks++; if (sample_req_o !== 1'b1 || underrun_o !== 1'b0) begin errors++; $display("FAIL load_pulses: got req=%b und=%b expected 1/0", sample_req_o, underrun_o); end
      adv_to(897);
      checks++; if (sample_req_o !== 1'b0 || s_ready_o !== 1'b1) begin errors++; $display("FAIL post_load: got req=%b rdy=%b expected 0/1", sample_req_o, s_ready_o); end
   endtask

   task automatic test_underrun();
      adv_to(1791);
      checks++; if (underrun_o !== 1'b0 || underrun_cnt_o !== 16'd0) begin errors++; $display("FAIL pre_underrun: got und=%b cnt=%0d expected 0/0", underrun_o, underrun_cnt_o); end
      adv_to(1792);
      checks++; if (underrun_o !== 1'b1 || sample_req_o !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got und=%b req=%b expected 1/1", underrun_o, sample_req_o); end
      checks++; if (underrun_cnt_o !== 16'd1) begin errors++; $display("FAIL underrun_cnt: got %0d expected 1", underrun_cnt_o); end
      checks++; if (audio_data_o !== 24'hABCDEF) begin errors++; $display("FAIL underrun_hold: got %h expected abcdef", audio_data_o); end
      adv_to(1793);
      checks++; if (underrun_o !== 1'b0) begin errors++; $display("FAIL underrun_one_cycle: got %b expected 0", underrun_o); end
   endtask

   task automatic test_back_to_back();
      adv_to(2000);
      push(24'h111111);
      adv_to(2687);
      s_valid_i = 1'b1; s_data_i = 24'h222222;
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL ready_on_load: got %b expected 1", s_ready_o); end
      step();
      s_valid_i = 1'b0;
      checks++; if (audio_data_o !== 24'h111111) begin errors++; $display("FAIL b2b_data: got %h expected 111111", audio_data_o); end
      checks++; if (underrun_o !== 1'b0 || underrun_cnt_o !== 16'd1) begin errors++; $display("FAIL b2b_no_underrun: got und=%b cnt=%0d expected 0/1", underrun_o, underrun_cnt_o); end
      checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_pending: got rdy=%b expected 0", s_ready_o); end
      adv_to(3584);
      checks++; if (audio_data_o !== 24'h222222) begin errors++; $display("FAIL b2b_second: got %h expected 222222", audio_data_o); end
      checks++; if (underrun_o !== 1'b0 || underrun_cnt_o !== 16'd1) begin errors++; $display("FAIL b2b_second_und: got und=%b cnt=%0d expected 0/1", underrun_o, underrun_cnt_o); end
   endtask

   task automatic test_freeze();
      int bad = 0;
      adv_to(3600);
      enable_i = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (audio_bclk_o !== 1'b0 || audio_lrclk_o !== 1'b1) bad++;
      end
      enable_i = 1'b1;
      checks++; if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d moving cycles expected 0", bad); end
      adv_to(3704); checks++; if (audio_bclk_o !== 1'b0) begin errors++; $display("FAIL bclk_c3704: got %b expected 0", audio_bclk_o); end
      adv_to(3705); checks++; if (audio_bclk_o !== 1'b1) begin errors++; $display("FAIL bclk_c3705: got %b expected 1", audio_bclk_o); end
      adv_to(4131); checks++; if (audio_lrclk_o !== 1'b1) begin errors++; $display("FAIL lrclk_c4131: got %b expected 1", audio_lrclk_o); end
      adv_to(4132); checks++; if (audio_lrclk_o !== 1'b0) begin errors++; $display("FAIL lrclk_c4132: got %b expected 0", audio_lrclk_o); end
   endtask

   task automatic test_mid_reset();
      adv_to(4200);
      push(24'h333333);
      rst_i = 1'b1;
      step();
      checks++; if (audio_lrclk_o !== 1'b1 || audio_bclk_o !== 1'b0) begin errors++; $display("FAIL mrst_clocks: got lr=%b bclk=%b expected 1/0", audio_lrclk_o, audio_bclk_o); end
      checks++; if (audio_data_o !== 24'h0 || underrun_cnt_o !== 16'h0) begin errors++; $display("FAIL mrst_data: got data=%h cnt=%0d expected 000000/0", audio_data_o, underrun_cnt_o); end
      checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_full: got rdy=%b expected 1", s_ready_o); end
      rst_i = 1'b0;
      cyc   = 0;
      adv_to(6); checks++; if (audio_bclk_o !== 1'b0) begin errors++; $display("FAIL mrst_bclk_c6: got %b expected 0", audio_bclk_o); end
      adv_to(7); checks++; if (audio_bclk_o !== 1'b1) begin errors++; $display("FAIL mrst_bclk_c7: got %b expected 1", audio_bclk_o); end
      adv_to(896);
      checks++; if (underrun_o !== 1'b1 || underrun_cnt_o !== 16'd1 || audio_data_o !== 24'h0) begin errors++; $display("FAIL mrst_discard: got und=%b cnt=%0d data=%h expected 1/1/000000", underrun_o, underrun_cnt_o, audio_data_o); end
   endtask

   initial begin
      test_reset();
      test_clocks_and_load();
      test_underrun();
      test_back_to_back();
      test_freeze();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
